// File: rtl/tm1638_display_driver_pkg.sv
// Shared TM1638 types and command bytes, plus the frame-builder FSM state encoding.
// No logic lives here.
package tm1638_types;
    typedef logic [7:0][7:0] segments_t;
    typedef logic [7:0]      leds_t;
    typedef logic [2:0]      grid_t;

    localparam logic [7:0] CMD_DATA_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0     = 8'hC0;
    localparam logic [7:0] CMD_DISP_ON   = 8'h88;
endpackage

package tm1638_driver_types;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_SEG  = 3'd3,
        S_LED  = 3'd4,
        S_CTRL = 3'd5
    } state_t;
endpackage

// File: rtl/tm1638_display_driver.sv
// TM1638 frame builder: latches an image, emits 19 words (one per cycle) into the SPI FIFO; stalls while FIFO full.
// Optional TM1638_PERIODIC_REFRESH_EN re-sends the last image after REFRESH_CYCLES idle cycles.
module tm1638_display_driver
    import tm1638_types::*;
    import tm1638_driver_types::*;
#(
    parameter logic [2:0] BRIGHTNESS     = 3'd7,
    parameter int         REFRESH_CYCLES = 100000
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  segments_t   i_Segments,
    input  leds_t       i_Leds,
    input  logic        i_Valid,
    input  logic        i_SPI_FIFO_Full,
    output logic [17:0] o_Data,
    output logic        o_Write,
    output state_t      o_Diag_State,
    output grid_t       o_Diag_Grid,
    output segments_t   o_Diag_Segments,
    output leds_t       o_Diag_Leds
);

    if (REFRESH_CYCLES < 1) begin : g_bad_refresh
        $error("REFRESH_CYCLES must be at least 1");
    end

    state_t    state, state_nxt;
    grid_t     grid, grid_nxt;
    logic      pending;
    segments_t pend_seg, act_seg;
    leds_t     pend_led, act_led;
    logic      load;
    logic      refresh_hit;

`ifdef TM1638_PERIODIC_REFRESH_EN
    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    logic [CNT_W-1:0] idle_cnt;

    // Counts only truly idle cycles; any frame activity restarts the interval.
    assign refresh_hit = (state == S_IDLE) && !pending &&
                         (idle_cnt == CNT_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            idle_cnt <= '0;
        end else if (state != S_IDLE || pending || refresh_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    assign o_Write = (state != S_IDLE) && !i_SPI_FIFO_Full;

    always_comb begin
        state_nxt = state;
        grid_nxt  = grid;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    load      = 1'b1;
                    state_nxt = S_CMD;
                end
            end
            S_CMD:  if (o_Write) state_nxt = S_ADDR;
            S_ADDR: if (o_Write) state_nxt = S_SEG;
            S_SEG:  if (o_Write) state_nxt = S_LED;
            S_LED: begin
                if (o_Write) begin
                    grid_nxt  = grid + 3'd1;
                    state_nxt = (grid == 3'd7) ? S_CTRL : S_SEG;
                end
            end
            S_CTRL: if (o_Write) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Word layout: {START, STOP, 8'h00, byte}; held stable while the FIFO is full.
    always_comb begin
        o_Data = '0;
        case (state)
            S_CMD:  o_Data = {2'b11, 8'h00, CMD_DATA_AUTO};
            S_ADDR: o_Data = {2'b10, 8'h00, CMD_ADDR0};
            S_SEG:  o_Data = {2'b00, 8'h00, act_seg[grid]};
            S_LED:  o_Data = {1'b0, (grid == 3'd7), 8'h00, 7'b0, act_led[grid]};
            S_CTRL: o_Data = {2'b11, 8'h00, CMD_DISP_ON | {5'b0, BRIGHTNESS}};
            default: o_Data = '0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state    <= S_IDLE;
            grid     <= '0;
            pending  <= 1'b0;
            pend_seg <= '0;
            pend_led <= '0;
            act_seg  <= '0;
            act_led  <= '0;
        end else begin
            state <= state_nxt;
            grid  <= grid_nxt;
            if (i_Valid) begin
                pend_seg <= i_Segments;
                pend_led <= i_Leds;
            end
            // A strobe coinciding with the load must survive for the next frame.
            if (i_Valid || refresh_hit) begin
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
            if (load) begin
                act_seg <= pend_seg;
                act_led <= pend_led;
            end
        end
    end

    assign o_Diag_State    = state;
    assign o_Diag_Grid     = grid;
    assign o_Diag_Segments = act_seg;
    assign o_Diag_Leds     = act_led;

endmodule

// File: tb/tb_tm1638_display_driver.sv
// Directed bench for tm1638_display_driver: frame content, backpressure, deferral, reset abort, refresh.
module tb_tm1638_display_driver;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic [63:0] i_Segments;
    logic [7:0]  i_Leds;
    logic        i_Valid;
    logic        i_SPI_FIFO_Full;
    logic [17:0] o_Data;
    logic        o_Write;
    logic [2:0]  o_Diag_State;
    logic [2:0]  o_Diag_Grid;
    logic [63:0] o_Diag_Segments;
    logic [7:0]  o_Diag_Leds;

    int vectors = 0;
    int miscompares = 0;

    int          st_cyc [3];
    logic [63:0] st_seg [3];
    logic [7:0]  st_led [3];
    logic [17:0] got [19];
    int          got_n, first_cyc, last_cyc;

    localparam logic [63:0] IMG_A = 64'h0000_0000_0000_003F;
    localparam logic [63:0] IMG_B = 64'hFF00_0000_0000_0000;
    localparam logic [63:0] IMG_C = 64'h0102_0304_0506_0708;
    localparam logic [63:0] IMG_D = 64'h1111_1111_1111_1111;
    localparam logic [63:0] IMG_E = 64'h8040_2010_0804_0201;

    tm1638_display_driver #(.BRIGHTNESS(3'd7), .REFRESH_CYCLES(50)) dut (
        .i_Clk           (i_Clk),
        .i_Rst           (i_Rst),
        .i_Segments      (i_Segments),
        .i_Leds          (i_Leds),
        .i_Valid         (i_Valid),
        .i_SPI_FIFO_Full (i_SPI_FIFO_Full),
        .o_Data          (o_Data),
        .o_Write         (o_Write),
        .o_Diag_State    (o_Diag_State),
        .o_Diag_Grid     (o_Diag_Grid),
        .o_Diag_Segments (o_Diag_Segments),
        .o_Diag_Leds     (o_Diag_Leds)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] exp_word(input int i, input logic [63:0] s, input logic [7:0] l);
        int g;
        if (i == 0)  return 18'h30040;
        if (i == 1)  return 18'h200C0;
        if (i == 18) return 18'h3008F;
        g = (i - 2) / 2;
        if (((i - 2) % 2) == 0) return {10'h000, s[g*8 +: 8]};
        return {1'b0, (g == 7), 15'h0000, l[g]};
    endfunction

    task automatic clear_strobes();
        for (int k = 0; k < 3; k++) st_cyc[k] = -1;
    endtask

    // Runs until stop_n words are written, applying scheduled strobes and optional random backpressure.
    task automatic collect(input int stop_n, input bit rnd);
        int          hold = 0;
        bit          pf = 0;
        bit          pnidle = 0;
        logic [17:0] pd = '0;
        got_n = 0;
        first_cyc = -1;
        last_cyc = -1;
        for (int cyc = 0; cyc < 3000 && got_n < stop_n; cyc++) begin
            @(negedge i_Clk);
            i_Valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (st_cyc[k] == cyc) begin
                    i_Valid    = 1'b1;
                    i_Segments = st_seg[k];
                    i_Leds     = st_led[k];
                end
            end
            if (rnd) begin
                if (hold == 0) begin
                    i_SPI_FIFO_Full = ~i_SPI_FIFO_Full;
                    hold = $urandom_range(2, 12);
                end
                hold--;
            end else begin
                i_SPI_FIFO_Full = 1'b0;
            end
            #1;
            if (pf && pnidle) check("data_hold_while_full", {46'h0, o_Data}, {46'h0, pd});
            if (i_SPI_FIFO_Full) check("no_write_while_full", {63'h0, o_Write}, 64'h0);
            if (o_Write) begin
                if (got_n == 0) first_cyc = cyc;
                last_cyc = cyc;
                got[got_n] = o_Data;
                got_n++;
            end
            pf     = i_SPI_FIFO_Full;
            pd     = o_Data;
            pnidle = (o_Diag_State != 3'd0);
        end
        check("word_count", 64'(got_n), 64'(stop_n));
        i_SPI_FIFO_Full = 1'b0;
        clear_strobes();
    endtask

    task automatic check_frame(input string tag, input logic [63:0] s, input logic [7:0] l);
        for (int i = 0; i < 19; i++) check(tag, {46'h0, got[i]}, {46'h0, exp_word(i, s, l)});
    endtask

    task automatic expect_idle(input int n, input string tag);
        int writes = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge i_Clk);
            i_Valid = 1'b0;
            i_SPI_FIFO_Full = 1'b0;
            #1;
            if (o_Write) writes++;
        end
        check(tag, 64'(writes), 64'h0);
    endtask

    initial begin
        logic [17:0] lit [19];
        i_Rst = 1'b0;
        i_Valid = 1'b0;
        i_SPI_FIFO_Full = 1'b0;
        i_Segments = '0;
        i_Leds = '0;
        clear_strobes();

        // Reset state
        repeat (3) @(negedge i_Clk);
        #1;
        check("rst_write", {63'h0, o_Write}, 64'h0);
        @(negedge i_Clk);
        i_Rst = 1'b1;
        #1;
        check("rst_write_after", {63'h0, o_Write}, 64'h0);
        check("rst_state", {61'h0, o_Diag_State}, 64'h0);
        check("rst_grid", {61'h0, o_Diag_Grid}, 64'h0);
        check("rst_diag_seg", o_Diag_Segments, 64'h0);
        check("rst_diag_led", {56'h0, o_Diag_Leds}, 64'h0);
        check("rst_data", {46'h0, o_Data}, 64'h0);
        expect_idle(10, "idle_before_valid");

        // Basic frame against a literal word table
        for (int i = 0; i < 19; i++) lit[i] = 18'h00000;
        lit[0] = 18'h30040; lit[1] = 18'h200C0; lit[2] = 18'h0003F; lit[3] = 18'h00001;
        lit[17] = 18'h10000; lit[18] = 18'h3008F;
        st_cyc[0] = 0; st_seg[0] = IMG_A; st_led[0] = 8'h01;
        collect(19, 1'b0);
        for (int i = 0; i < 19; i++) check("frame_a_literal", {46'h0, got[i]}, {46'h0, lit[i]});
        check("frame_a_consecutive", 64'(last_cyc - first_cyc), 64'd18);
        check("frame_a_first_cycle", 64'(first_cyc), 64'd2);
        check("diag_seg_a", o_Diag_Segments, IMG_A);
        check("diag_led_a", {56'h0, o_Diag_Leds}, 64'h01);
        @(negedge i_Clk);
        #1;
        check("idle_after_frame", {61'h0, o_Diag_State}, 64'h0);

        // Mid-frame update is deferred to the next frame
        st_cyc[0] = 0; st_seg[0] = IMG_A; st_led[0] = 8'h01;
        st_cyc[1] = 8; st_seg[1] = IMG_B; st_led[1] = 8'h80;
        collect(19, 1'b0);
        check_frame("deferred_cur_frame", IMG_A, 8'h01);
        collect(19, 1'b0);
        check_frame("deferred_next_frame", IMG_B, 8'h80);
        check("led7_stop_word", {46'h0, got[17]}, 64'h10001);

        // Two mid-frame strobes: only the last is sent next
        st_cyc[0] = 0;  st_seg[0] = IMG_C; st_led[0] = 8'h55;
        st_cyc[1] = 6;  st_seg[1] = IMG_D; st_led[1] = 8'hAA;
        st_cyc[2] = 10; st_seg[2] = IMG_E; st_led[2] = 8'h3C;
        collect(19, 1'b0);
        check_frame("multi_cur_frame", IMG_C, 8'h55);
        collect(19, 1'b0);
        check_frame("multi_last_wins", IMG_E, 8'h3C);
        expect_idle(10, "no_extra_frame");

        // Random backpressure
        st_cyc[0] = 0; st_seg[0] = IMG_A; st_led[0] = 8'h01;
        collect(19, 1'b1);
        check_frame("backpressure_frame", IMG_A, 8'h01);

`ifdef TM1638_PERIODIC_REFRESH_EN
        collect(19, 1'b0);
        check_frame("refresh_frame", IMG_A, 8'h01);
        check("refresh_delay", {63'h0, (first_cyc >= 45 && first_cyc <= 56)}, 64'h1);
`else
        expect_idle(150, "no_refresh_without_macro");
`endif

        // Reset mid-frame after 9 words
        st_cyc[0] = 0; st_seg[0] = IMG_C; st_led[0] = 8'h55;
        collect(9, 1'b0);
        @(negedge i_Clk);
        i_Rst = 1'b0;
        #1;
        check("abort_write", {63'h0, o_Write}, 64'h0);
        check("abort_state", {61'h0, o_Diag_State}, 64'h0);
        check("abort_grid", {61'h0, o_Diag_Grid}, 64'h0);
        check("abort_diag_seg", o_Diag_Segments, 64'h0);
        @(negedge i_Clk);
        i_Rst = 1'b1;
        expect_idle(30, "idle_after_abort");
        check("abort_state_after", {61'h0, o_Diag_State}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
